// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer, gshare-folded index, flush sweep (option: BTB_TARGET_EN)
module btb_assoc #(
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [29:0]           pc_r,
  input  logic [INDEX_BITS-1:0] ghr,
  output logic                  hit_r,
  output logic [1:0]            way_r,
  output logic [INDEX_BITS-1:0] index_r,
  output logic [29:0]           target_r,
  input  logic                  wen,
  input  logic [INDEX_BITS-1:0] index_w,
  input  logic [29:0]           pc_w,
  input  logic [29:0]           target_w,
  input  logic                  flush,
  output logic                  busy
);

  localparam int         SETS     = 1 << INDEX_BITS;
  localparam logic [1:0] PTR_LAST = 2'(WAYS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state;
  logic [INDEX_BITS-1:0]   sweep_cnt;
  logic [WAYS-1:0]         valid  [SETS];
  logic [1:0]              rr_ptr [SETS];
  logic [29:0]             tag_mem[SETS][WAYS];

  logic [INDEX_BITS-1:0]   rd_idx;
  logic                    wr_en;
  logic                    wr_match;
  logic [1:0]              wr_match_way;
  logic [1:0]              wr_way;
  logic                    rd_hit;
  logic [1:0]              rd_way;
  logic                    bypass;
  logic                    lk_hit;
  logic [1:0]              lk_way;

  assign rd_idx = pc_r[INDEX_BITS-1:0] ^ ghr;
  // Writes are dropped while sweeping and in the cycle a flush is accepted.
  assign wr_en  = wen && (state == IDLE) && !flush;
  assign wr_way = wr_match ? wr_match_way : rr_ptr[index_w];
  assign bypass = wr_en && (index_w == rd_idx) && (pc_w == pc_r);
  assign busy   = (state == SWEEP);

  // Find an existing valid copy of pc_w in the target set (in-place update).
  always_comb begin
    wr_match     = 1'b0;
    wr_match_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_match && valid[index_w][w] && (tag_mem[index_w][w] == pc_w)) begin
        wr_match     = 1'b1;
        wr_match_way = 2'(w);
      end
    end
  end

  // Tag compare across all ways of the looked-up set.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!rd_hit && valid[rd_idx][w] && (tag_mem[rd_idx][w] == pc_r)) begin
        rd_hit = 1'b1;
        rd_way = 2'(w);
      end
    end
  end

  // Lookup result before registering: sweep forces a miss, bypass wins over stored data.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = 2'd0;
    if (state == IDLE) begin
      if (bypass) begin
        lk_hit = 1'b1;
        lk_way = wr_way;
      end else if (rd_hit) begin
        lk_hit = 1'b1;
        lk_way = rd_way;
      end
    end
  end

  // Sweep controller: one set cleared per cycle, flush ignored once sweeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end
        end
        SWEEP: begin
          if (&sweep_cnt) begin
            state     <= IDLE;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + INDEX_BITS'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

  // Valid bits and round-robin pointers; the pointer only moves on allocation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= 2'd0;
      end
    end else if (state == SWEEP) begin
      valid[sweep_cnt]  <= '0;
      rr_ptr[sweep_cnt] <= 2'd0;
    end else if (wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_way == 2'(w)) valid[index_w][w] <= 1'b1;
      end
      if (!wr_match) begin
        rr_ptr[index_w] <= (rr_ptr[index_w] == PTR_LAST) ? 2'd0 : rr_ptr[index_w] + 2'd1;
      end
    end
  end

  // Tag storage is never reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_way == 2'(w)) tag_mem[index_w][w] <= pc_w;
      end
    end
  end

  // Registered lookup outputs, held while rd_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_r   <= 1'b0;
      way_r   <= 2'd0;
      index_r <= '0;
    end else if (rd_en) begin
      hit_r   <= lk_hit;
      way_r   <= lk_way;
      index_r <= rd_idx;
    end
  end

`ifdef BTB_TARGET_EN
  logic [29:0] tgt_mem[SETS][WAYS];
  logic [29:0] rd_tgt;

  // Target of the hitting way, zero on a miss.
  always_comb begin
    rd_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_hit && (rd_way == 2'(w))) rd_tgt = tgt_mem[rd_idx][w];
    end
  end

  // Target storage, written alongside the tag; not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_way == 2'(w)) tgt_mem[index_w][w] <= target_w;
      end
    end
  end

  // Registered target, following the same hold/force-miss rules as hit_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r <= '0;
    end else if (rd_en) begin
      if (state != IDLE)  target_r <= '0;
      else if (bypass)    target_r <= target_w;
      else                target_r <= rd_tgt;
    end
  end
`else
  // Tag-only mode: direction comes from gshare, so no target is kept.
  logic unused_target;
  assign unused_target = ^target_w;
  assign target_r      = '0;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - self-checking bench for btb_assoc against a behavioural set model
module tb_btb_assoc;

  localparam int IB   = 6;
  localparam int W    = 2;
  localparam int SETS = 64;
`ifdef BTB_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rd_en, wen, flush;
  logic [29:0] pc_r, pc_w, target_w;
  logic [5:0]  ghr, index_w;
  logic        hit_r, busy;
  logic [1:0]  way_r;
  logic [5:0]  index_r;
  logic [29:0] target_r;

  always #5 clk = ~clk;

  btb_assoc #(.INDEX_BITS(IB), .WAYS(W)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .pc_r(pc_r), .ghr(ghr),
    .hit_r(hit_r), .way_r(way_r), .index_r(index_r), .target_r(target_r),
    .wen(wen), .index_w(index_w), .pc_w(pc_w), .target_w(target_w),
    .flush(flush), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each set is a small table of entries plus a victim counter.
  bit          m_val[SETS][W];
  logic [29:0] m_tag[SETS][W];
  logic [29:0] m_tgt[SETS][W];
  int          m_ptr[SETS];
  int          sweep_left;
  logic        e_hit;
  logic [1:0]  e_way;
  logic [5:0]  e_idx;
  logic [29:0] e_tgt;

  function automatic logic [29:0] tgt(input logic [29:0] t);
    return TGT_EN ? t : 30'd0;
  endfunction

  function automatic int find(input int set, input logic [29:0] pc);
    for (int w = 0; w < W; w++)
      if (m_val[set][w] && m_tag[set][w] == pc) return w;
    return -1;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < W; w++) m_val[s][w] = 1'b0;
      m_ptr[s] = 0;
    end
  endtask

  task automatic cyc(input bit rst, input bit rd, input logic [29:0] pcr, input logic [5:0] g,
                     input bit w, input logic [5:0] iw, input logic [29:0] pcw,
                     input logic [29:0] tw, input bit fl);
    bit sweeping, we;
    int idx, ww, h, m;
    reset = rst; rd_en = rd; pc_r = pcr; ghr = g;
    wen = w; index_w = iw; pc_w = pcw; target_w = tw; flush = fl;
    if (rst) begin
      clear_model();
      sweep_left = 0;
      e_hit = 0; e_way = 0; e_idx = 0; e_tgt = 0;
    end else begin
      sweeping = (sweep_left > 0);
      we = w && !sweeping && !fl;
      idx = int'(pcr[5:0] ^ g);
      ww = -1;
      if (we) begin
        ww = find(int'(iw), pcw);
        if (ww < 0) ww = m_ptr[iw];
      end
      if (rd) begin
        e_idx = 6'(idx); e_hit = 0; e_way = 0; e_tgt = 0;
        if (!sweeping) begin
          if (we && int'(iw) == idx && pcw == pcr) begin
            e_hit = 1; e_way = 2'(ww); e_tgt = tgt(tw);
          end else begin
            h = find(idx, pcr);
            if (h >= 0) begin
              e_hit = 1; e_way = 2'(h); e_tgt = tgt(m_tgt[idx][h]);
            end
          end
        end
      end
      if (we) begin
        m = find(int'(iw), pcw);
        if (m >= 0) m_tgt[iw][m] = tw;
        else begin
          m_val[iw][ww] = 1'b1; m_tag[iw][ww] = pcw; m_tgt[iw][ww] = tw;
          m_ptr[iw] = (m_ptr[iw] + 1) % W;
        end
      end
      if (sweeping) sweep_left--;
      else if (fl) begin
        clear_model();
        sweep_left = SETS;
      end
    end
    @(posedge clk);
    #1;
    check("hit", hit_r, e_hit);
    check("way", way_r, e_way);
    check("idx", index_r, e_idx);
    check("tgt", target_r, e_tgt);
    check("busy", busy, sweep_left > 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [5:0] iw, input logic [29:0] pcw, input logic [29:0] tw);
    cyc(0, 0, 0, 0, 1, iw, pcw, tw, 0);
  endtask
  task automatic rd(input logic [29:0] pcr, input logic [5:0] g);
    cyc(0, 1, pcr, g, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int bc;
    logic [29:0] p, q;
    logic [5:0]  g1, g2;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_hit", hit_r, 0);
    check("rst_busy", busy, 0);
    check("rst_tgt", target_r, 0);

    wr(6'h05, 30'h105, 30'h200);
    idle();
    rd(30'h105, 6'h00);
    check("wr_rd_hit", hit_r, 1);
    check("wr_rd_idx", index_r, 6'h05);
    check("wr_rd_tgt", target_r, tgt(30'h200));
    cyc(0, 0, 30'h3FF, 6'h11, 0, 0, 0, 0, 0);
    check("hold_hit", hit_r, 1);
    check("hold_idx", index_r, 6'h05);

    wr(6'h05, 30'h145, 30'h210);
    wr(6'h05, 30'h185, 30'h220);
    rd(30'h105, 6'h00);
    check("evict_first", hit_r, 0);
    check("evict_tgt0", target_r, 0);
    rd(30'h145, 6'h00);
    check("second_hit", hit_r, 1);
    check("second_way", way_r, 1);
    rd(30'h185, 6'h00);
    check("third_hit", hit_r, 1);
    check("third_way", way_r, 0);

    wr(6'h05, 30'h185, 30'h300);
    rd(30'h185, 6'h00);
    check("inplace_way", way_r, 0);
    check("inplace_tgt", target_r, tgt(30'h300));
    wr(6'h05, 30'h1C5, 30'h230);
    rd(30'h1C5, 6'h00);
    check("ptr_kept_way", way_r, 1);
    rd(30'h145, 6'h00);
    check("ptr_kept_evict", hit_r, 0);

    cyc(0, 1, 30'h105, 6'h00, 1, 6'h05, 30'h105, 30'h400, 0);
    check("bypass_hit", hit_r, 1);
    check("bypass_way", way_r, 0);
    check("bypass_tgt", target_r, tgt(30'h400));

    wr(6'h05, 30'h10A, 30'h500);
    rd(30'h10A, 6'h0F);
    check("ghr_hit", hit_r, 1);
    check("ghr_idx", index_r, 6'h05);

    cyc(0, 0, 0, 0, 1, 6'h23, 30'h123, 30'h55, 1);
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      cyc(0, 1, 30'h105, 6'h00, 1, 6'h23, 30'h123, 30'h77, bc == 10);
    end
    check("flush_len", bc, 64);
    rd(30'h123, 6'h00);
    check("flush_wen_dropped", hit_r, 0);
    rd(30'h105, 6'h00);
    check("flush_inval_a", hit_r, 0);
    rd(30'h10A, 6'h0F);
    check("flush_inval_b", hit_r, 0);

    wr(6'h07, 30'h207, 30'h600);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) idle();
    check("mid_sweep_busy", busy, 1);
    cyc(1, 1, 30'h207, 6'h00, 1, 6'h07, 30'h207, 30'h600, 1);
    check("rst_sweep_busy", busy, 0);
    check("rst_sweep_hit", hit_r, 0);
    check("rst_sweep_idx", index_r, 0);
    rd(30'h207, 6'h00);
    check("rst_sweep_inval", hit_r, 0);

    for (int i = 0; i < 3000; i++) begin
      p  = 30'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      q  = 30'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      g1 = 6'($urandom_range(0, 3));
      g2 = 6'($urandom_range(0, 3));
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, p, g1,
          $urandom_range(0, 1) == 1, q[5:0] ^ g2, q, 30'($urandom),
          $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
